// File: rtl/serial_reg_bridge_pkg.sv
// serial_reg_bridge_pkg: shared constants and FSM state encoding
// for the serial command bridge and its timeout counter.
package serial_reg_bridge_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      W_ADDR,
      W_DATA,
      R_ADDR,
      REPLY
   } state_t;

endpackage

// File: rtl/serial_reg_bridge_timeout.sv
// serial_byte_timeout: idle-cycle counter between command bytes.
// Ports: clk, rst, clr (restart count), en (counting), expired (strobe).
module serial_byte_timeout #(
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   // A clear in the same cycle wins over expiry (a byte beats the timeout).
   assign expired = en && !clr && (count == LAST);

endmodule

// File: rtl/serial_reg_bridge.sv
// serial_reg_bridge: parses 'W' addr data / 'R' addr byte commands,
// owns an 8-bit register file and returns one reply byte per command.
// Ports: clk, rst, rx_data/new_rx_data (in), tx_data/new_tx_data/tx_busy,
// reg_out (flattened regs), wr_stb/wr_addr (write notify), err (sticky).
module serial_reg_bridge
   import serial_reg_bridge_pkg::*;
#(
   parameter int NUM_REGS       = 8,
   parameter int ADDR_W         = 3,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  new_rx_data,
   output logic [7:0]            tx_data,
   output logic                  new_tx_data,
   input  logic                  tx_busy,
   output logic [8*NUM_REGS-1:0] reg_out,
   output logic                  wr_stb,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic                  err
);

   state_t     state;
   logic [7:0] addr_q;
   logic [7:0] reply_q;
   logic [7:0] rd_val;
   logic       rx_ok;
   logic       addr_ok;
   logic       tmo_en;
   logic       tmo_clr;
   logic       expired;

   assign tmo_en  = (state == W_ADDR) || (state == W_DATA) ||
                    (state == R_ADDR);
   assign tmo_clr = new_rx_data || !tmo_en;

   serial_byte_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expired(expired)
   );

   // Range checks use the whole address byte so aliases are rejected.
   assign rx_ok   = {1'b0, rx_data} < 9'(NUM_REGS);
   assign addr_ok = {1'b0, addr_q} < 9'(NUM_REGS);

   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (rx_data == 8'(k)) rd_val = reg_out[8*k +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         reply_q     <= '0;
         tx_data     <= '0;
         new_tx_data <= 1'b0;
         reg_out     <= '0;
         wr_stb      <= 1'b0;
         wr_addr     <= '0;
         err         <= 1'b0;
      end else begin
         new_tx_data <= 1'b0;
         wr_stb      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (new_rx_data) begin
                  if (rx_data == CMD_WRITE) begin
                     state <= W_ADDR;
                  end else if (rx_data == CMD_READ) begin
                     state <= R_ADDR;
                  end else begin
                     reply_q <= RSP_ERR;
                     err     <= 1'b1;
                     state   <= REPLY;
                  end
               end
            end
            W_ADDR: begin
               if (new_rx_data) begin
                  addr_q <= rx_data;
                  state  <= W_DATA;
               end else if (expired) begin
                  state <= IDLE;
               end
            end
            W_DATA: begin
               if (new_rx_data) begin
                  if (addr_ok) begin
                     for (int k = 0; k < NUM_REGS; k++) begin
                        if (addr_q == 8'(k)) reg_out[8*k +: 8] <= rx_data;
                     end
                     wr_stb  <= 1'b1;
                     wr_addr <= ADDR_W'(addr_q);
                     reply_q <= RSP_ACK;
                  end else begin
                     reply_q <= RSP_ERR;
                     err     <= 1'b1;
                  end
                  state <= REPLY;
               end else if (expired) begin
                  state <= IDLE;
               end
            end
            R_ADDR: begin
               if (new_rx_data) begin
                  if (rx_ok) begin
                     reply_q <= rd_val;
                  end else begin
                     reply_q <= RSP_ERR;
                     err     <= 1'b1;
                  end
                  state <= REPLY;
               end else if (expired) begin
                  state <= IDLE;
               end
            end
            REPLY: begin
               // Bytes arriving while a reply is pending are discarded.
               if (new_rx_data) err <= 1'b1;
               if (!tx_busy) begin
                  tx_data     <= reply_q;
                  new_tx_data <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_reg_bridge.sv
// tb_serial_reg_bridge: directed scoreboard bench for serial_reg_bridge.
// Expected replies and writes are queued at stimulus time; a monitor pops them.
module tb_serial_reg_bridge;

   localparam int NR = 8;
   localparam int AW = 3;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      rx_data = '0;
   logic            new_rx_data = 1'b0;
   logic            tx_busy = 1'b0;
   logic [7:0]      tx_data;
   logic            new_tx_data;
   logic [8*NR-1:0] reg_out;
   logic            wr_stb;
   logic [AW-1:0]   wr_addr;
   logic            err;

   serial_reg_bridge #(
      .NUM_REGS(NR),
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .new_rx_data(new_rx_data),
      .tx_data    (tx_data),
      .new_tx_data(new_tx_data),
      .tx_busy    (tx_busy),
      .reg_out    (reg_out),
      .wr_stb     (wr_stb),
      .wr_addr    (wr_addr),
      .err        (err)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_bad = 0;
   int         n_strobe = 0;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_wa[$];
   logic [7:0] exp_wd[$];
   logic [7:0] mem[NR];
   bit         rand_busy = 0;
   logic [7:0] mon_a;
   logic [7:0] mon_d;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [8*NR-1:0] model_flat();
      logic [8*NR-1:0] v;
      v = '0;
      for (int k = 0; k < NR; k++) v[8*k +: 8] = mem[k];
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (new_tx_data) begin
            n_strobe++;
            if (exp_tx.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL tx_extra: got strobe %0h, none required",
                        tx_data);
            end else begin
               chk("tx_data", tx_data, exp_tx.pop_front());
            end
         end
         if (wr_stb) begin
            if (exp_wa.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL wr_extra: got write addr %0h, none required",
                        wr_addr);
            end else begin
               mon_a = exp_wa.pop_front();
               mon_d = exp_wd.pop_front();
               chk("wr_addr", wr_addr, mon_a);
               chk("wr_reg", reg_out[8*mon_a +: 8], mon_d);
            end
         end
      end
   end

   task automatic send(logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data     = b;
      new_rx_data = 1'b1;
      @(posedge clk);
      #1;
      new_rx_data = 1'b0;
      rx_data     = '0;
   endtask

   task automatic do_write(logic [7:0] a, logic [7:0] d);
      send(8'h57);
      send(a);
      if (a < NR) begin
         exp_wa.push_back(a);
         exp_wd.push_back(d);
         mem[a[AW-1:0]] = d;
         exp_tx.push_back(8'h4B);
      end else begin
         exp_tx.push_back(8'h3F);
      end
      send(d);
   endtask

   task automatic do_read(logic [7:0] a);
      if (a < NR) exp_tx.push_back(mem[a[AW-1:0]]);
      else exp_tx.push_back(8'h3F);
      send(8'h52);
      send(a);
   endtask

   task automatic wait_done(string name);
      int i;
      for (i = 0; i < 500; i++) begin
         if (exp_tx.size() == 0 && exp_wa.size() == 0) break;
         @(posedge clk);
         #1;
         if (rand_busy) tx_busy = ($urandom_range(0, 2) == 0);
      end
      if (i == 500) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: got %0d replies pending, required 0",
                  name, exp_tx.size());
         exp_tx.delete();
         exp_wa.delete();
         exp_wd.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_tx.delete();
      exp_wa.delete();
      exp_wd.delete();
      for (int k = 0; k < NR; k++) mem[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int s0;

   initial begin
      for (int k = 0; k < NR; k++) mem[k] = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_reg_out", reg_out, '0);
      chk("rst_tx_data", tx_data, '0);
      chk("rst_new_tx", new_tx_data, 0);
      chk("rst_wr_stb", wr_stb, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;

      // write with exact timing
      do_write(8'h03, 8'hA5);
      chk("t1_reg3", reg_out[31:24], 8'hA5);
      chk("t1_wr_stb", wr_stb, 1);
      chk("t1_wr_addr", wr_addr, 3);
      chk("t1_no_tx_yet", new_tx_data, 0);
      @(posedge clk);
      #1;
      chk("t1_tx_strobe", new_tx_data, 1);
      chk("t1_tx_ack", tx_data, 8'h4B);
      @(posedge clk);
      #1;
      chk("t1_tx_single", new_tx_data, 0);
      chk("t1_err", err, 0);
      wait_done("t1_wait");

      // read back, then out-of-range read
      do_read(8'h03);
      wait_done("t2_read");
      chk("t2_err_clean", err, 0);
      do_read(8'h09);
      wait_done("t2_bad_read");
      chk("t2_err_set", err, 1);
      chk("t2_regs", reg_out, model_flat());
      do_write(8'h0B, 8'h66);
      wait_done("t2_alias_write");
      chk("t2_alias_regs", reg_out, model_flat());

      // unknown command, dropped byte under tx_busy
      do_reset();
      chk("t3_err_rst", err, 0);
      exp_tx.push_back(8'h3F);
      send(8'h41);
      wait_done("t3_unknown");
      chk("t3_err", err, 1);
      tx_busy = 1'b1;
      exp_tx.push_back(8'h3F);
      send(8'h41);
      s0 = n_strobe;
      send(8'h57);
      repeat (100) @(posedge clk);
      #1;
      chk("t3_held", n_strobe, s0);
      tx_busy = 1'b0;
      @(posedge clk);
      #1;
      chk("t3_release", new_tx_data, 1);
      wait_done("t3_reply");
      do_read(8'h03);
      wait_done("t3_read");

      // timeout abandons an orphaned write
      s0 = n_strobe;
      send(8'h57);
      send(8'h01);
      repeat (20) @(posedge clk);
      #1;
      chk("t4_no_reply", n_strobe, s0);
      chk("t4_err_same", err, 1);
      do_read(8'h01);
      wait_done("t4_read");
      send(8'h57);
      send(8'h02);
      repeat (12) @(posedge clk);
      exp_wa.push_back(8'h02);
      exp_wd.push_back(8'h77);
      mem[2] = 8'h77;
      exp_tx.push_back(8'h4B);
      send(8'h77);
      wait_done("t4_late_write");
      chk("t4_regs", reg_out, model_flat());

      // asynchronous reset with a pending reply
      do_write(8'h00, 8'h5A);
      wait_done("t5_write");
      tx_busy = 1'b1;
      send(8'h52);
      send(8'h00);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_reg_out", reg_out, '0);
      chk("t5_tx_data", tx_data, '0);
      chk("t5_new_tx", new_tx_data, 0);
      chk("t5_wr_stb", wr_stb, 0);
      chk("t5_wr_addr", wr_addr, 0);
      chk("t5_err", err, 0);
      for (int k = 0; k < NR; k++) mem[k] = '0;
      s0 = n_strobe;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tx_busy = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t5_no_strobe", n_strobe, s0);
      do_read(8'h00);
      wait_done("t5_read");

      // back-to-back pairs with random busy gaps
      rand_busy = 1;
      s0 = n_strobe;
      for (int i = 0; i < 10; i++) begin
         do_write(8'(i % 8), 8'($urandom_range(0, 255)));
         wait_done("t6_write");
         do_read(8'(i % 8));
         wait_done("t6_read");
      end
      rand_busy = 0;
      tx_busy = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_strobes", n_strobe, s0 + 20);
      chk("t6_regs", reg_out, model_flat());
      chk("t6_err", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
